// File: rtl/wsl_pkg.sv
// Shared defaults, derived widths and FSM state encoding for weight_stream_loader.
package wsl_pkg;

    localparam int DEF_W_WIDTH   = 10;
    localparam int DEF_N_WEIGHTS = 16;
    localparam int WS_WIDTH      = DEF_N_WEIGHTS * DEF_W_WIDTH;
    localparam int CNT_WIDTH     = $clog2(DEF_N_WEIGHTS + 1);

    typedef enum logic [1:0] {
        FILL_W = 2'd0,
        FILL_B = 2'd1,
        HOLD   = 2'd2
    } wsl_state_t;

endpackage

// File: rtl/weight_stream_loader_ws_pack_reg.sv
// Fill buffer: N_WEIGHTS weight slots written by word index, presented packed with
// the first weight at the MSB end of the bus.
module ws_pack_reg
    import wsl_pkg::*;
#(
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int N_WEIGHTS = DEF_N_WEIGHTS,
    localparam int CNT_W    = $clog2(N_WEIGHTS + 1)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [CNT_W-1:0]             wr_idx,
    input  logic [W_WIDTH-1:0]           wr_data,
    output logic [N_WEIGHTS*W_WIDTH-1:0] fill_bus
);

    logic [W_WIDTH-1:0] slot [N_WEIGHTS];

    // Slots are data only: no reset, unwritten slots keep whatever they held.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_WEIGHTS; k++) begin
            if (wr_en && (wr_idx == CNT_W'(k))) begin
                slot[k] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < N_WEIGHTS; k++) begin : g_pack
        assign fill_bus[(N_WEIGHTS-1-k)*W_WIDTH +: W_WIDTH] = slot[k];
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Packs N_WEIGHTS weights plus a bias into one double-buffered frame for the MAC.
// Optional framing check on w_last is enabled by defining WSL_LAST_CHECK_EN.
module weight_stream_loader
    import wsl_pkg::*;
#(
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int N_WEIGHTS = DEF_N_WEIGHTS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [W_WIDTH-1:0]           w_data,
    input  logic                         w_last,
    output logic [N_WEIGHTS*W_WIDTH-1:0] ws,
    output logic [W_WIDTH-1:0]           bias,
    output logic                         ws_valid,
    input  logic                         ws_ready,
    output logic                         frame_err
);

    localparam int CNT_W = $clog2(N_WEIGHTS + 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(N_WEIGHTS - 1);

    wsl_state_t                   state;
    logic [CNT_W-1:0]             count;
    logic [W_WIDTH-1:0]           bias_buf;
    logic [N_WEIGHTS*W_WIDTH-1:0] fill_bus;
    logic                         err_q;
    logic                         w_acc;
    logic                         slot_free;
    logic                         word_err;

    assign w_ready   = !reset && (state != HOLD);
    assign w_acc     = w_valid && w_ready;
    assign slot_free = !ws_valid || ws_ready;
    assign frame_err = err_q;

`ifdef WSL_LAST_CHECK_EN
    // Weights must arrive with w_last low and the bias with w_last high.
    assign word_err = w_acc && ((state == FILL_W) ? w_last : !w_last);
`else
    logic unused_last;
    assign unused_last = w_last;
    assign word_err    = 1'b0;
`endif

    ws_pack_reg #(
        .W_WIDTH   (W_WIDTH),
        .N_WEIGHTS (N_WEIGHTS)
    ) u_pack (
        .clk      (clk),
        .wr_en    (w_acc && (state == FILL_W) && !word_err),
        .wr_idx   (count),
        .wr_data  (w_data),
        .fill_bus (fill_bus)
    );

    always_ff @(posedge clk) begin
        if (state == FILL_B && w_acc && !word_err && !slot_free) begin
            bias_buf <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL_W;
            count    <= '0;
            ws       <= '0;
            bias     <= '0;
            ws_valid <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // A consume clears valid unless a reload below overrides it.
            if (ws_valid && ws_ready) begin
                ws_valid <= 1'b0;
            end
            if (word_err) begin
                err_q <= 1'b1;
            end
            case (state)
                FILL_W: begin
                    if (w_acc) begin
                        if (word_err) begin
                            count <= '0;
                        end else if (count == LAST_W) begin
                            count <= '0;
                            state <= FILL_B;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                FILL_B: begin
                    if (w_acc) begin
                        if (word_err) begin
                            state <= FILL_W;
                        end else if (slot_free) begin
                            ws       <= fill_bus;
                            bias     <= w_data;
                            ws_valid <= 1'b1;
                            state    <= FILL_W;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        ws       <= fill_bus;
                        bias     <= bias_buf;
                        ws_valid <= 1'b1;
                        state    <= FILL_W;
                    end
                end
                default: begin
                    state <= FILL_W;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
